mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 15 +
 rtl/rr_arbiter2.sv | 38 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester RAM arbiter.
package mem_arbiter_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant; the pointer remembers the last accepted requester.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] valid,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_idx
);

  // last_q = 1 after reset so requester 0 wins the first contest
  logic last_q;

  always_comb begin
    grant_idx = 1'b0;
    if (valid[0] && valid[1]) begin
      grant_idx = ~last_q;
    end else if (valid[1]) begin
      grant_idx = 1'b1;
    end
    grant = '0;
    if (enable && (|valid)) begin
      grant = onehot2(grant_idx);
    end
  end

  // A grant with its valid high is an acceptance, so the pointer moves only then
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (|grant) begin
      last_q <= grant[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one synchronous-read RAM port; partial writes
// are done as read-modify-write through a one-cycle MERGE state.
//
// state    | meaning
// ST_IDLE  | accept one request per cycle; reads, full and zero-mask writes finish at +1
// ST_MERGE | write merged word of a captured partial write; no acceptance
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter  int W = 32,
  parameter  int L = 128,
  localparam int A = $clog2(L),
  localparam int B = W / 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0][A-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0][W-1:0] req_wdata,
  input  logic [NUM_REQ-1:0][B-1:0] req_wmask,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [W-1:0]              rsp_rdata,
  output logic                      ram_wr_ena,
  output logic [A-1:0]              ram_addr,
  output logic [W-1:0]              ram_wr_data,
  input  logic [W-1:0]              ram_rd_data
);

  state_t               state_q, state_d;
  logic                 rdy_en_q;
  logic [NUM_REQ-1:0]   grant;
  logic                 gidx;
  logic                 accept;
  logic [A-1:0]         sel_addr;
  logic                 sel_wr;
  logic [W-1:0]         sel_wdata;
  logic [B-1:0]         sel_mask;
  logic                 sel_full;
  logic                 sel_none;
  logic                 is_partial;
  logic [A-1:0]         cap_addr;
  logic [W-1:0]         cap_data;
  logic [B-1:0]         cap_mask;
  logic                 cap_idx;
  logic [W-1:0]         merged;
  logic [NUM_REQ-1:0]   rsp_d;
  logic [NUM_REQ-1:0]   rsp_q;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (req_valid),
    .enable    (rdy_en_q && (state_q == ST_IDLE)),
    .grant     (grant),
    .grant_idx (gidx)
  );

  assign req_ready  = grant;
  assign accept     = |(req_valid & grant);
  assign sel_addr   = req_addr[gidx];
  assign sel_wr     = req_wr[gidx];
  assign sel_wdata  = req_wdata[gidx];
  assign sel_mask   = req_wmask[gidx];
  assign sel_full   = &sel_mask;
  assign sel_none   = ~|sel_mask;
  assign is_partial = accept && sel_wr && !sel_full && !sel_none;

  // The pre-write word read at acceptance arrives on ram_rd_data during MERGE
  always_comb begin
    merged = '0;
    for (int k = 0; k < B; k++) begin
      merged[8*k +: 8] = cap_mask[k] ? cap_data[8*k +: 8] : ram_rd_data[8*k +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    ram_wr_ena  = 1'b0;
    ram_addr    = sel_addr;
    ram_wr_data = sel_wdata;
    rsp_d       = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (is_partial) begin
            state_d = ST_MERGE;
          end else begin
            ram_wr_ena = sel_wr && sel_full;
            rsp_d      = onehot2(gidx);
          end
        end
      end
      ST_MERGE: begin
        ram_wr_ena  = 1'b1;
        ram_addr    = cap_addr;
        ram_wr_data = merged;
        rsp_d       = onehot2(cap_idx);
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // rdy_en_q keeps req_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rdy_en_q <= 1'b0;
      rsp_q    <= '0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
      rsp_q    <= rsp_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= '0;
      cap_data <= '0;
      cap_mask <= '0;
      cap_idx  <= 1'b0;
    end else if (is_partial) begin
      cap_addr <= sel_addr;
      cap_data <= sel_wdata;
      cap_mask <= sel_mask;
      cap_idx  <= gidx;
    end
  end

  // Read-before-write RAM makes ram_rd_data the pre-write word for partial writes too
  assign rsp_valid = rsp_q;
  assign rsp_rdata = ram_rd_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: RAM model, reference memory and response scoreboard.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam int L = 128;
  localparam int A = 7;

  logic                clk;
  logic                rst_n;
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][A-1:0]   req_addr;
  logic [1:0]          req_wr;
  logic [1:0][W-1:0]   req_wdata;
  logic [1:0][3:0]     req_wmask;
  logic [1:0]          rsp_valid;
  logic [W-1:0]        rsp_rdata;
  logic                ram_wr_ena;
  logic [A-1:0]        ram_addr;
  logic [W-1:0]        ram_wr_data;
  logic [W-1:0]        ram_rd_data;

  mem_arbiter #(.W(W), .L(L)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_wr      (req_wr),
    .req_wdata   (req_wdata),
    .req_wmask   (req_wmask),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .ram_wr_ena  (ram_wr_ena),
    .ram_addr    (ram_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [W-1:0] mem     [L];
  logic [W-1:0] ref_mem [L];

  always @(posedge clk) begin
    ram_rd_data <= mem[ram_addr];
    if (ram_wr_ena) mem[ram_addr] <= ram_wr_data;
  end

  int total = 0;
  int bad   = 0;
  int cycle = 0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [W-1:0] merge_w(input logic [W-1:0] old, input logic [W-1:0] nw,
                                           input logic [3:0] m);
    logic [W-1:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = m[k] ? nw[8*k +: 8] : old[8*k +: 8];
    return r;
  endfunction

  typedef struct {
    int           idx;
    logic [W-1:0] data;
    bit           chk;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  int           merge_due = -1;
  logic [A-1:0] merge_addr;
  logic [W-1:0] merge_data;

  // Scoreboard: expectations pushed at acceptance, popped when rsp_valid appears
  always @(negedge clk) begin
    logic [1:0]   acc;
    logic         exp_we;
    logic [A-1:0] a;
    logic [W-1:0] old;
    exp_t         e;
    if (!rst_n) begin
      sbq.delete();
      merge_due = -1;
      check("rst_ready", 64'(req_ready), 64'(0));
      check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
      check("rst_ram_wr_ena", 64'(ram_wr_ena), 64'(0));
    end else begin
      if (rsp_valid != 2'b00) begin
        check("rsp_onehot", 64'(rsp_valid == 2'b11), 64'(0));
        if (sbq.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = sbq.pop_front();
          check("rsp_latency", 64'(cycle), 64'(e.due));
          check("rsp_requester", 64'(rsp_valid), 64'(e.idx == 1 ? 2'b10 : 2'b01));
          if (e.chk) check("rsp_rdata", 64'(rsp_rdata), 64'(e.data));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cycle) begin
        e = sbq.pop_front();
        check("rsp_missing", 64'(0), 64'(1));
      end
      acc    = req_valid & req_ready;
      exp_we = 1'b0;
      if (acc == 2'b11) check("accept_both", 64'(acc), 64'(0));
      if (merge_due == cycle) begin
        exp_we    = 1'b1;
        merge_due = -1;
        check("merge_addr", 64'(ram_addr), 64'(merge_addr));
        check("merge_data", 64'(ram_wr_data), 64'(merge_data));
      end
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          a = req_addr[i];
          check("accept_ram_addr", 64'(ram_addr), 64'(a));
          if (!req_wr[i]) begin
            sbq.push_back('{idx: i, data: ref_mem[a], chk: 1'b1, due: cycle + 1});
          end else if (req_wmask[i] == 4'hF) begin
            exp_we     = 1'b1;
            ref_mem[a] = req_wdata[i];
            check("full_wr_data", 64'(ram_wr_data), 64'(req_wdata[i]));
            sbq.push_back('{idx: i, data: '0, chk: 1'b0, due: cycle + 1});
          end else if (req_wmask[i] == 4'h0) begin
            sbq.push_back('{idx: i, data: '0, chk: 1'b0, due: cycle + 1});
          end else begin
            old        = ref_mem[a];
            ref_mem[a] = merge_w(old, req_wdata[i], req_wmask[i]);
            merge_due  = cycle + 1;
            merge_addr = a;
            merge_data = ref_mem[a];
            sbq.push_back('{idx: i, data: old, chk: 1'b1, due: cycle + 2});
          end
        end
      end
      check("ram_wr_ena", 64'(ram_wr_ena), 64'(exp_we));
    end
  end

  typedef struct {
    logic [1:0]   valid;
    logic [1:0]   wr;
    logic [A-1:0] a0;
    logic [A-1:0] a1;
    logic [W-1:0] d0;
    logic [W-1:0] d1;
    logic [1:0]   exp_ready;
    logic         exp_we;
  } vec_t;

  vec_t vec [10];

  task automatic idle_all();
    req_valid = 2'b00;
    req_wr    = 2'b00;
    req_wmask = '1;
  endtask

  task automatic drive(input int i, input logic wr, input logic [A-1:0] addr,
                       input logic [W-1:0] data, input logic [3:0] mask);
    req_valid[i] = 1'b1;
    req_wr[i]    = wr;
    req_addr[i]  = addr;
    req_wdata[i] = data;
    req_wmask[i] = mask;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < L; k++) begin
      mem[k]     = 32'hA500_0000 + k;
      ref_mem[k] = 32'hA500_0000 + k;
    end
    mem[9]     = 32'h1122_3344;
    ref_mem[9] = 32'h1122_3344;

    vec[0] = '{2'b00, 2'b00, 7'd20, 7'd21, 32'h0,         32'h0,         2'b00, 1'b0};
    vec[1] = '{2'b11, 2'b00, 7'd20, 7'd21, 32'h0,         32'h0,         2'b01, 1'b0};
    vec[2] = '{2'b11, 2'b00, 7'd22, 7'd23, 32'h0,         32'h0,         2'b10, 1'b0};
    vec[3] = '{2'b11, 2'b00, 7'd20, 7'd21, 32'h0,         32'h0,         2'b01, 1'b0};
    vec[4] = '{2'b11, 2'b00, 7'd22, 7'd23, 32'h0,         32'h0,         2'b10, 1'b0};
    vec[5] = '{2'b01, 2'b01, 7'd24, 7'd0,  32'hCAFE_0001, 32'h0,         2'b01, 1'b1};
    vec[6] = '{2'b10, 2'b00, 7'd0,  7'd24, 32'h0,         32'h0,         2'b10, 1'b0};
    vec[7] = '{2'b11, 2'b10, 7'd26, 7'd25, 32'h0,         32'h1234_5678, 2'b01, 1'b0};
    vec[8] = '{2'b11, 2'b10, 7'd26, 7'd25, 32'h0,         32'h1234_5678, 2'b10, 1'b1};
    vec[9] = '{2'b00, 2'b00, 7'd0,  7'd0,  32'h0,         32'h0,         2'b00, 1'b0};

    req_addr  = '0;
    req_wdata = '0;
    idle_all();
    rst_n = 1'b0;
    drive(0, 1'b0, 7'd0, 32'h0, 4'hF);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 check("ready_before_first_edge", 64'(req_ready), 64'(2'b00));
    next_cycle();
    check("ready_after_first_edge", 64'(req_ready), 64'(2'b01));
    idle_all();

    // Grant and round-robin table
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      req_valid    = vec[k].valid;
      req_wr       = vec[k].wr;
      req_addr[0]  = vec[k].a0;
      req_addr[1]  = vec[k].a1;
      req_wdata[0] = vec[k].d0;
      req_wdata[1] = vec[k].d1;
      req_wmask    = '1;
      @(negedge clk);
      check($sformatf("tbl%0d_ready", k), 64'(req_ready), 64'(vec[k].exp_ready));
      check($sformatf("tbl%0d_we", k), 64'(ram_wr_ena), 64'(vec[k].exp_we));
    end
    next_cycle();
    idle_all();
    repeat (3) next_cycle();

    // Full write then read-back of the same word
    drive(0, 1'b1, 7'd5, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    check("s36_wr_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    drive(0, 1'b0, 7'd5, 32'h0, 4'hF);
    @(negedge clk);
    check("s36_rd_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    idle_all();
    repeat (3) next_cycle();
    check("s36_mem5", 64'(mem[5]), 64'(32'hDEAD_BEEF));

    // Partial write with a read of the same word queued behind it
    drive(0, 1'b1, 7'd9, 32'h0000_AA00, 4'b0010);
    @(negedge clk);
    check("s37_accept_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    drive(0, 1'b0, 7'd9, 32'h0, 4'hF);
    @(negedge clk);
    check("s37_merge_ready", 64'(req_ready), 64'(2'b00));
    next_cycle();
    @(negedge clk);
    check("s37_after_merge_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    idle_all();
    repeat (3) next_cycle();
    check("s37_mem9", 64'(mem[9]), 64'(32'h1122_AA44));

    // r1 partial write; r0 arrives during MERGE and must stall one cycle
    drive(1, 1'b1, 7'd12, 32'hBBCC_0000, 4'b1100);
    @(negedge clk);
    check("s39_r1_ready", 64'(req_ready), 64'(2'b10));
    next_cycle();
    idle_all();
    drive(0, 1'b0, 7'd12, 32'h0, 4'hF);
    @(negedge clk);
    check("s39_merge_stall", 64'(req_ready), 64'(2'b00));
    next_cycle();
    @(negedge clk);
    check("s39_r0_accept", 64'(req_ready), 64'(2'b01));
    next_cycle();
    idle_all();
    repeat (3) next_cycle();
    check("s39_mem12", 64'(mem[12]), 64'(32'hBBCC_000C));

    // Zero-mask write is acknowledged but leaves RAM alone
    drive(0, 1'b1, 7'd7, 32'hFFFF_FFFF, 4'h0);
    @(negedge clk);
    check("s41_ready", 64'(req_ready), 64'(2'b01));
    check("s41_no_we", 64'(ram_wr_ena), 64'(0));
    next_cycle();
    idle_all();
    repeat (3) next_cycle();
    check("s41_mem7", 64'(mem[7]), 64'(32'hA500_0007));

    // Reset during MERGE abandons the write and its response
    drive(0, 1'b1, 7'd3, 32'h0000_00EE, 4'b0001);
    @(negedge clk);
    check("s40_accept_ready", 64'(req_ready), 64'(2'b01));
    next_cycle();
    idle_all();
    #1 rst_n = 1'b0;
    #1 check("s40_reset_we", 64'(ram_wr_ena), 64'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    ref_mem[3] = 32'hA500_0003;
    repeat (2) next_cycle();
    check("s40_mem3", 64'(mem[3]), 64'(32'hA500_0003));
    drive(0, 1'b0, 7'd3, 32'h0, 4'hF);
    @(negedge clk);
    check("s40_idle_after_reset", 64'(req_ready), 64'(2'b01));
    next_cycle();
    idle_all();
    repeat (4) next_cycle();

    check("sb_drained", 64'(sbq.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
